// File: rtl/pic_top.sv
// Programmable interrupt controller: latches requests, applies mask and fixed priority
// (IRQ0 highest), fully nested. Define PIC_IRQ_SYNC_EN to add a 2-flop irq_i synchronizer.
module pic_top #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        adr_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               int_o
);

  logic [NUM_IRQ-1:0] irr, isr, imr, itr, irq_prev, irq_in;
  logic [NUM_IRQ-1:0] irr_next, isr_next, req;
  logic [3:0]         p_idx, s_idx;
  logic               eligible;
  logic               access, wr, rd, vec_ack, eoi_wr;
  logic [2:0]         reg_sel;
  logic [31:0]        rd_data;
  logic               unused_ok;

  assign unused_ok = ^{sel_i, adr_i[31:5], adr_i[1:0], dat_i};

`ifdef PIC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_i;
      sync2 <= sync1;
    end
  end

  assign irq_in = sync2;
`else
  assign irq_in = irq_i;
`endif

  // A transaction is accepted only on the cycle where ack_o is about to rise.
  assign access  = cyc_i & stb_i & ~ack_o;
  assign wr      = access & we_i;
  assign rd      = access & ~we_i;
  assign reg_sel = adr_i[4:2];
  assign eoi_wr  = wr && (reg_sel == 3'd5);
  assign req     = irr & ~imr;

  always_comb begin
    p_idx = 4'd0;
    s_idx = 4'd0;
    for (int n = NUM_IRQ - 1; n >= 0; n--) begin
      if (req[n]) p_idx = 4'(n);
      if (isr[n]) s_idx = 4'(n);
    end
    eligible = (req != '0) && ((isr == '0) || (p_idx < s_idx));
    vec_ack  = rd && (reg_sel == 3'd4) && eligible;
  end

  // In edge mode a new edge overrides a same-cycle acknowledge clear.
  always_comb begin
    irr_next = irr;
    isr_next = isr;
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (itr[n]) begin
        irr_next[n] = irq_in[n];
      end else begin
        if (vec_ack && (p_idx == 4'(n))) irr_next[n] = 1'b0;
        if (irq_in[n] && !irq_prev[n])   irr_next[n] = 1'b1;
      end
      if (vec_ack && (p_idx == 4'(n))) isr_next[n] = 1'b1;
      if (eoi_wr && ((dat_i[8] && (isr != '0) && (s_idx == 4'(n))) ||
                     (!dat_i[8] && (dat_i[3:0] == 4'(n)))))
        isr_next[n] = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd0: rd_data[NUM_IRQ-1:0] = irr;
      3'd1: rd_data[NUM_IRQ-1:0] = imr;
      3'd2: rd_data[NUM_IRQ-1:0] = isr;
      3'd3: rd_data[NUM_IRQ-1:0] = itr;
      3'd4: if (eligible) rd_data = {1'b1, 27'b0, p_idx};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irr      <= '0;
      isr      <= '0;
      imr      <= '1;
      itr      <= '0;
      irq_prev <= '0;
      dat_o    <= '0;
      ack_o    <= 1'b0;
      int_o    <= 1'b0;
    end else begin
      ack_o    <= access;
      dat_o    <= rd ? rd_data : 32'h0;
      int_o    <= eligible;
      irr      <= irr_next;
      isr      <= isr_next;
      irq_prev <= irq_in;
      if (wr && (reg_sel == 3'd1)) imr <= dat_i[NUM_IRQ-1:0];
      if (wr && (reg_sel == 3'd3)) itr <= dat_i[NUM_IRQ-1:0];
    end
  end

endmodule

// File: tb/tb_pic_top.sv
// Self-checking bench for pic_top: register table plus directed interrupt sequences.
// Latency expectations follow PIC_IRQ_SYNC_EN when it is defined.
module tb_pic_top;

  localparam int NUM_IRQ = 8;
`ifdef PIC_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  localparam logic [31:0] A_IRR = 32'h00, A_IMR = 32'h04, A_ISR = 32'h08, A_ITR = 32'h0C;
  localparam logic [31:0] A_VEC = 32'h10, A_EOI = 32'h14;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]         sel_i = 4'hF;
  logic [31:0]        adr_i = '0, dat_i = '0;
  logic [31:0]        dat_o;
  logic               ack_o, int_o;
  logic [NUM_IRQ-1:0] irq_i = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vectors [22];

  pic_top #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .irq_i(irq_i), .int_o(int_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata);
    bit got = 0;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = addr; dat_i = wdata;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (ack_o) begin
        got = 1;
        break;
      end
    end
    rdata = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("[TB] FAIL ack_timeout: no ack for addr 0x%08h", addr);
    end
  endtask

  task automatic rdCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    applyStimulus(1'b0, addr, 32'h0, d);
    checkOutput(name, d, expected);
  endtask

  task automatic wrReg(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    applyStimulus(1'b1, addr, data, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulseIrq(input int n);
    @(negedge clk_i);
    irq_i[n] = 1'b1;
    @(negedge clk_i);
    irq_i[n] = 1'b0;
  endtask

  initial begin
    logic [31:0] d;

    vectors[0]  = '{1'b0, A_IMR,        32'h0,         32'h0000_00FF};
    vectors[1]  = '{1'b0, A_IRR,        32'h0,         32'h0};
    vectors[2]  = '{1'b0, A_ISR,        32'h0,         32'h0};
    vectors[3]  = '{1'b0, A_ITR,        32'h0,         32'h0};
    vectors[4]  = '{1'b0, A_VEC,        32'h0,         32'h0};
    vectors[5]  = '{1'b0, A_EOI,        32'h0,         32'h0};
    vectors[6]  = '{1'b0, 32'h18,       32'h0,         32'h0};
    vectors[7]  = '{1'b0, 32'h1C,       32'h0,         32'h0};
    vectors[8]  = '{1'b0, 32'h0000_0104, 32'h0,        32'h0000_00FF};
    vectors[9]  = '{1'b1, A_IMR,        32'h0000_00A5, 32'h0};
    vectors[10] = '{1'b0, A_IMR,        32'h0,         32'h0000_00A5};
    vectors[11] = '{1'b1, A_IMR,        32'hFFFF_FF3C, 32'h0};
    vectors[12] = '{1'b0, A_IMR,        32'h0,         32'h0000_003C};
    vectors[13] = '{1'b1, A_ITR,        32'h0000_0081, 32'h0};
    vectors[14] = '{1'b0, A_ITR,        32'h0,         32'h0000_0081};
    vectors[15] = '{1'b1, A_ITR,        32'h0,         32'h0};
    vectors[16] = '{1'b1, 32'h18,       32'h0000_0012, 32'h0};
    vectors[17] = '{1'b1, A_IRR,        32'h0000_00FF, 32'h0};
    vectors[18] = '{1'b1, A_ISR,        32'h0000_00FF, 32'h0};
    vectors[19] = '{1'b0, A_IMR,        32'h0,         32'h0000_003C};
    vectors[20] = '{1'b0, A_ISR,        32'h0,         32'h0};
    vectors[21] = '{1'b1, A_IMR,        32'h0000_00FF, 32'h0};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("reset_int", {31'b0, int_o}, 32'h0);
    checkOutput("reset_ack", {31'b0, ack_o}, 32'h0);
    checkOutput("reset_dat", dat_o, 32'h0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vectors[i].we, vectors[i].addr, vectors[i].wdata, d);
      checkOutput($sformatf("vec%0d", i), d, vectors[i].exp);
    end
    idle(1);
    checkOutput("ack_single_pulse", {31'b0, ack_o}, 32'h0);

    // Held strobe: ack toggles 1,0,1,0.
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = A_IMR;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checkOutput($sformatf("held_ack%0d", k), {31'b0, ack_o}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;

    // Basic flow on IRQ0.
    wrReg(A_IMR, 32'hFE);
    pulseIrq(0);
    idle(LAT - 2);
    checkOutput("basic_int_early", {31'b0, int_o}, 32'h0);
    idle(1);
    checkOutput("basic_int_rise", {31'b0, int_o}, 32'h1);
    rdCheck("basic_irr", A_IRR, 32'h01);
    rdCheck("basic_vec", A_VEC, 32'h8000_0000);
    idle(1);
    checkOutput("basic_int_drop", {31'b0, int_o}, 32'h0);
    rdCheck("basic_isr", A_ISR, 32'h01);
    rdCheck("basic_irr_clr", A_IRR, 32'h0);
    wrReg(A_EOI, 32'h100);
    rdCheck("basic_isr_eoi", A_ISR, 32'h0);

    // Priority and nesting.
    wrReg(A_IMR, 32'h0);
    pulseIrq(3);
    idle(LAT - 1);
    checkOutput("prio_int3", {31'b0, int_o}, 32'h1);
    rdCheck("prio_vec3", A_VEC, 32'h8000_0003);
    idle(1);
    checkOutput("prio_int3_drop", {31'b0, int_o}, 32'h0);
    pulseIrq(5);
    idle(LAT);
    checkOutput("prio_int5_blocked", {31'b0, int_o}, 32'h0);
    rdCheck("prio_irr5", A_IRR, 32'h20);
    pulseIrq(1);
    idle(LAT - 1);
    checkOutput("prio_int1", {31'b0, int_o}, 32'h1);
    rdCheck("prio_vec1", A_VEC, 32'h8000_0001);
    rdCheck("prio_isr_0a", A_ISR, 32'h0A);
    wrReg(A_EOI, 32'h100);
    rdCheck("prio_isr_08", A_ISR, 32'h08);
    checkOutput("prio_int_nested", {31'b0, int_o}, 32'h0);
    wrReg(A_EOI, 32'h003);
    rdCheck("prio_isr_clr3", A_ISR, 32'h0);
    idle(1);
    checkOutput("prio_int5", {31'b0, int_o}, 32'h1);
    rdCheck("prio_vec5", A_VEC, 32'h8000_0005);
    wrReg(A_EOI, 32'h00D);
    rdCheck("eoi_out_of_range", A_ISR, 32'h20);
    wrReg(A_EOI, 32'h100);
    rdCheck("prio_isr_final", A_ISR, 32'h0);

    // Level mode on IRQ2.
    wrReg(A_ITR, 32'h04);
    @(negedge clk_i);
    irq_i[2] = 1'b1;
    idle(LAT);
    checkOutput("level_int", {31'b0, int_o}, 32'h1);
    rdCheck("level_vec", A_VEC, 32'h8000_0002);
    idle(1);
    checkOutput("level_int_in_service", {31'b0, int_o}, 32'h0);
    rdCheck("level_irr_kept", A_IRR, 32'h04);
    wrReg(A_EOI, 32'h002);
    checkOutput("level_int_eoi_early", {31'b0, int_o}, 32'h0);
    idle(1);
    checkOutput("level_int_eoi", {31'b0, int_o}, 32'h1);
    irq_i[2] = 1'b0;
    idle(LAT);
    checkOutput("level_int_drop", {31'b0, int_o}, 32'h0);
    rdCheck("level_irr_drop", A_IRR, 32'h0);
    wrReg(A_ITR, 32'h0);

    // Spurious acknowledge with an in-service bit held.
    pulseIrq(6);
    idle(LAT);
    rdCheck("spur_setup_vec", A_VEC, 32'h8000_0006);
    rdCheck("spur_vec", A_VEC, 32'h0);
    rdCheck("spur_isr", A_ISR, 32'h40);
    wrReg(A_EOI, 32'h100);

    // Masking a pending request.
    wrReg(A_IMR, 32'hFF);
    pulseIrq(4);
    idle(LAT);
    checkOutput("mask_int_off", {31'b0, int_o}, 32'h0);
    rdCheck("mask_irr", A_IRR, 32'h10);
    wrReg(A_IMR, 32'hEF);
    idle(1);
    checkOutput("unmask_int", {31'b0, int_o}, 32'h1);
    wrReg(A_IMR, 32'hFF);
    checkOutput("mask_int_hold", {31'b0, int_o}, 32'h1);
    idle(1);
    checkOutput("mask_int_drop", {31'b0, int_o}, 32'h0);
    rdCheck("mask_irr_kept", A_IRR, 32'h10);
    wrReg(A_IMR, 32'hEF);
    rdCheck("mask_vec4", A_VEC, 32'h8000_0004);
    wrReg(A_EOI, 32'h100);

    // New IRQ0 edge on the same edge as its acknowledge.
    wrReg(A_IMR, 32'hFE);
    pulseIrq(0);
    idle(LAT);
    rdCheck("coll_irr_pre", A_IRR, 32'h01);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = A_VEC; irq_i[0] = 1'b1;
    @(negedge clk_i);
    checkOutput("coll_ack", {31'b0, ack_o}, 32'h1);
    checkOutput("coll_vec", dat_o, 32'h8000_0000);
    cyc_i = 1'b0; stb_i = 1'b0; irq_i[0] = 1'b0;
    idle(LAT);
    rdCheck("coll_irr", A_IRR, 32'h01);
    rdCheck("coll_isr", A_ISR, 32'h01);
    wrReg(A_EOI, 32'h100);
    rdCheck("coll_vec2", A_VEC, 32'h8000_0000);
    wrReg(A_EOI, 32'h100);

    // Reset on the accepting edge of a write.
    wrReg(A_IMR, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = A_IMR; dat_i = 32'h55;
    @(negedge clk_i);
    checkOutput("rst_mid_ack", {31'b0, ack_o}, 32'h0);
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    rdCheck("rst_mid_imr", A_IMR, 32'hFF);
    rdCheck("rst_mid_isr", A_ISR, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
